regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Sequences and shares the register file's single write port (regwrite/wa/wd) between two writeback requesters, A (ALU/execute) and B (load/memory).
- After reset it runs an init pass that zeroes registers 1..2^REGBITS-1.
- It then arbitrates requests round-robin and drives the write port from registers.
- It sits between the writeback stage and the register file.

Parameters:
WIDTH, 32, data width of a register
REGBITS, 5, register address width (2^REGBITS registers; register 0 hardwired zero)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_a_valid  input  1  requester A has a write pending
req_a_ready  output  1  A's request accepted this cycle (combinational)
req_a_addr  input  REGBITS  A destination register
req_a_data  input  WIDTH  A write data
req_b_valid  input  1  requester B has a write pending
req_b_ready  output  1  B's request accepted this cycle (combinational)
req_b_addr  input  REGBITS  B destination register
req_b_data  input  WIDTH  B write data
regwrite  output  1  register file write enable (registered)
wa  output  REGBITS  register file write address (registered)
wd  output  WIDTH  register file write data (registered)
init_done  output  1  high once the init pass completes (registered)

Behaviour:
- Reset (asynchronous, immediate):
  - state=INIT, init counter=1, priority pointer=A.
  - regwrite=0, wa=0, wd=0, init_done=0.
  - req_a_ready=req_b_ready=0.
- INIT state:
  - On each edge: regwrite<=1, wa<=counter, wd<=0, counter<=counter+1.
  - On the edge that launches wa=2^REGBITS-1: state<=RUN.
  - Following edge: init_done<=1 and regwrite<=0, unless a RUN transfer occurs in that first RUN cycle.
  - Exactly 2^REGBITS-1 write cycles (31 by default); register 0 is never written.
  - Both ready outputs stay 0 throughout INIT, even if valid is asserted.
- RUN state (never left except by reset); init_done stays 1.
- Grant rules, combinational in RUN:
  - Only one valid: that requester's ready=1.
  - Both valid: the requester named by the priority pointer gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle.
- Transfer: valid && ready on the same edge.
- Pointer update: after a granted transfer, the pointer moves to the non-granted requester. With no transfer, the pointer holds.
- Write-port output on a transfer edge:
  - wa<=addr, wd<=data.
  - regwrite<=1 if addr!=0, else regwrite<=0.
  - A write to register 0 is accepted and silently dropped.
- No transfer: regwrite<=0; wa and wd hold their previous values.
- Latency:
  - Handshake at edge N gives regwrite=1 after edge N.
  - The register file commits at edge N+1.
  - Back-to-back transfers give regwrite=1 on consecutive cycles; throughput is 1 write per cycle.
- Same address from both requesters: serialized by the pointer; the later-granted write wins. No merging.
- Requester protocol: valid, addr and data must be held stable until ready. The arbiter does not handle withdrawal; the bench asserts this rule.
- Reset mid-operation: all in-flight and accepted-but-unwritten state is discarded, and INIT restarts from wa=1.

Test Plan:
1. Release reset, no requests -> regwrite=1 for 31 consecutive cycles with wa=1,2,...,31 and wd=0. Then regwrite=0 and init_done=1; no write to wa=0 at any point.
2. After init, A only: valid addr=5 data=0xDEADBEEF -> req_a_ready=1 that cycle. Next cycle regwrite=1, wa=5, wd=0xDEADBEEF for exactly one cycle.
3. Both held valid after init (A addr=3 data=1, B addr=4 data=2, re-presenting new data after each accept) -> grants alternate A,B,A,B. regwrite stays high continuously with wa=3,4,3,4.
4. A valid addr=0 data=0x1234 -> req_a_ready=1, regwrite stays 0, wa/wd updated to 0/0x1234. The pointer still moves to B.
5. A and B valid during INIT -> both readies 0 for all 31 init cycles. A is granted in the first RUN cycle, and B in the next.
6. Reset asserted mid-RUN while regwrite=1 -> regwrite and init_done go to 0 immediately, without waiting for a clock edge. After release, INIT restarts at wa=1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write-port sequencer and arbiter.
// After reset it zeroes registers 1..2^REGBITS-1, one per cycle. It then shares
// the single write port between requester A (execute) and requester B (memory)
// using a round-robin pointer. All write-port outputs are registered.
module regfile_write_arbiter #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a_valid,
  output logic               req_a_ready,
  input  logic [REGBITS-1:0] req_a_addr,
  input  logic [WIDTH-1:0]   req_a_data,
  input  logic               req_b_valid,
  output logic               req_b_ready,
  input  logic [REGBITS-1:0] req_b_addr,
  input  logic [WIDTH-1:0]   req_b_data,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               init_done
);

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  localparam logic [REGBITS-1:0] LastReg  = '1;
  localparam logic [REGBITS-1:0] FirstReg = REGBITS'(1);

  state_e             state_q, state_d;
  logic [REGBITS-1:0] cnt_q, cnt_d;
  logic               ptrB_q, ptrB_d;
  logic               regwrite_q, regwrite_d;
  logic [REGBITS-1:0] wa_q, wa_d;
  logic [WIDTH-1:0]   wd_q, wd_d;
  logic               initDone_q, initDone_d;
  logic               grantA, grantB;

  // State register: INIT after reset, RUN forever once the last register is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StInit;
    else       state_q <= state_d;
  end

  // Next state: leave INIT on the edge that launches the highest register address.
  always_comb begin
    state_d = state_q;
    if (state_q == StInit && cnt_q == LastReg) state_d = StRun;
  end

  // Grant outputs: only in RUN; when both requesters are valid, the pointer decides.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (state_q == StRun) begin
      grantA = req_a_valid && (!req_b_valid || !ptrB_q);
      grantB = req_b_valid && (!req_a_valid ||  ptrB_q);
    end
  end

  assign req_a_ready = grantA;
  assign req_b_ready = grantB;

  // Datapath next-state: init sweep, or the accepted write; writes to register 0 are dropped.
  always_comb begin
    cnt_d      = cnt_q;
    ptrB_d     = ptrB_q;
    regwrite_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    initDone_d = initDone_q;
    if (state_q == StInit) begin
      regwrite_d = 1'b1;
      wa_d       = cnt_q;
      wd_d       = '0;
      cnt_d      = cnt_q + 1'b1;
    end else begin
      initDone_d = 1'b1;
      if (grantA) begin
        wa_d       = req_a_addr;
        wd_d       = req_a_data;
        regwrite_d = (req_a_addr != '0);
        ptrB_d     = 1'b1;
      end else if (grantB) begin
        wa_d       = req_b_addr;
        wd_d       = req_b_data;
        regwrite_d = (req_b_addr != '0);
        ptrB_d     = 1'b0;
      end
    end
  end

  // Datapath registers: reset discards any accepted-but-unwritten request and restarts init at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= FirstReg;
      ptrB_q     <= 1'b0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      initDone_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ptrB_q     <= ptrB_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      initDone_q <= initDone_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign init_done = initDone_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a reference model pushes the
// expected write-port state into a queue as each cycle is driven, and the
// entry is popped and compared once the DUT has produced that cycle's output.
module tb_regfile_write_arbiter;

  localparam int WIDTH   = 32;
  localparam int REGBITS = 5;
  localparam int NREG    = 1 << REGBITS;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_a_valid = 1'b0;
  logic               req_a_ready;
  logic [REGBITS-1:0] req_a_addr = '0;
  logic [WIDTH-1:0]   req_a_data = '0;
  logic               req_b_valid = 1'b0;
  logic               req_b_ready;
  logic [REGBITS-1:0] req_b_addr = '0;
  logic [WIDTH-1:0]   req_b_data = '0;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic               init_done;

  typedef struct {
    logic               rw;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic               done;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  bit   mRun;
  int   mCnt;
  bit   mPtrB;
  exp_t mOut;

  regfile_write_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_addr(req_a_addr), .req_a_data(req_a_data),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
    .req_b_addr(req_b_addr), .req_b_data(req_b_data),
    .regwrite(regwrite), .wa(wa), .wd(wd), .init_done(init_done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Counts every comparison and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mRun  = 1'b0;
    mCnt  = 1;
    mPtrB = 1'b0;
    mOut  = '{rw: 1'b0, wa: '0, wd: '0, done: 1'b0};
    expQ.delete();
  endtask

  task automatic applyStimulus(input bit av, input logic [REGBITS-1:0] aa, input logic [WIDTH-1:0] ad,
                               input bit bv, input logic [REGBITS-1:0] ba, input logic [WIDTH-1:0] bd);
    req_a_valid = av;
    req_a_addr  = aa;
    req_a_data  = ad;
    req_b_valid = bv;
    req_b_addr  = ba;
    req_b_data  = bd;
  endtask

  // One clock cycle, entered and left at a falling edge: check grants, predict, clock, compare.
  task automatic runCycle();
    bit   gA, gB;
    exp_t nxt, got;
    #1;
    gA = mRun && req_a_valid && (!req_b_valid || !mPtrB);
    gB = mRun && req_b_valid && (!req_a_valid ||  mPtrB);
    checkOutput("readyA", req_a_ready, gA);
    checkOutput("readyB", req_b_ready, gB);
    nxt    = mOut;
    nxt.rw = 1'b0;
    if (!mRun) begin
      nxt.rw = 1'b1;
      nxt.wa = REGBITS'(mCnt);
      nxt.wd = '0;
      if (mCnt == NREG - 1) mRun = 1'b1;
      mCnt++;
    end else begin
      nxt.done = 1'b1;
      if (gA) begin
        nxt.wa = req_a_addr; nxt.wd = req_a_data; nxt.rw = (req_a_addr != 0); mPtrB = 1'b1;
      end else if (gB) begin
        nxt.wa = req_b_addr; nxt.wd = req_b_data; nxt.rw = (req_b_addr != 0); mPtrB = 1'b0;
      end
    end
    mOut = nxt;
    expQ.push_back(nxt);
    @(posedge clk);
    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 1, 0);
    end else begin
      got = expQ.pop_front();
      checkOutput("regwrite", regwrite, got.rw);
      checkOutput("wa", wa, got.wa);
      checkOutput("wd", wd, got.wd);
      checkOutput("initDone", init_done, got.done);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Requester protocol: a valid request not yet accepted must be held stable.
  logic               pendA, pendB;
  logic [REGBITS-1:0] pAddrA, pAddrB;
  logic [WIDTH-1:0]   pDataA, pDataB;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pendA <= 1'b0;
      pendB <= 1'b0;
    end else begin
      if (pendA) checkOutput("holdA", {req_a_valid, req_a_addr, req_a_data}, {1'b1, pAddrA, pDataA});
      if (pendB) checkOutput("holdB", {req_b_valid, req_b_addr, req_b_data}, {1'b1, pAddrB, pDataB});
      pendA  <= req_a_valid && !req_a_ready;
      pendB  <= req_b_valid && !req_b_ready;
      pAddrA <= req_a_addr;
      pDataA <= req_a_data;
      pAddrB <= req_b_addr;
      pDataB <= req_b_data;
    end
  end

  // Directed sequence covering init, single writes, round-robin, register 0 and reset.
  initial begin
    logic [WIDTH-1:0] aData, bData;
    modelReset();
    #1;
    checkOutput("rstRegwrite", regwrite, 0);
    checkOutput("rstInitDone", init_done, 0);
    checkOutput("rstWa", wa, 0);
    checkOutput("rstReadyA", req_a_ready, 0);
    doReset();

    // Init sweep writes 1..31 with zero data, then goes idle with init_done set.
    for (int k = 1; k < NREG; k++) begin
      runCycle();
      checkOutput("initWa", wa, k);
      checkOutput("initRw", regwrite, 1);
      checkOutput("initWd", wd, 0);
    end
    runCycle();
    checkOutput("postInitRw", regwrite, 0);
    checkOutput("postInitDone", init_done, 1);

    // Single write from A.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    #1 checkOutput("t2ReadyA", req_a_ready, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2Wa", wa, 5);
    checkOutput("t2Wd", wd, 32'hDEADBEEF);
    checkOutput("t2Rw", regwrite, 1);
    runCycle();
    checkOutput("t2RwOff", regwrite, 0);

    // Single write from B returns the pointer to A.
    applyStimulus(0, 0, 0, 1, 7, 32'h77);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("bOnlyWa", wa, 7);

    // Both valid: A,B,A,B with continuous regwrite.
    aData = 1;
    bData = 2;
    applyStimulus(1, 3, aData, 1, 4, bData);
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput("rrReadyA", req_a_ready, (i % 2 == 0));
      runCycle();
      checkOutput("rrWa", wa, (i % 2 == 0) ? 3 : 4);
      checkOutput("rrRw", regwrite, 1);
      if (i % 2 == 0) begin
        aData++;
        req_a_data  = aData;
        req_a_valid = (i < 2);
      end else begin
        bData++;
        req_b_data  = bData;
        req_b_valid = (i < 2);
      end
    end

    // Write to register 0 is accepted but dropped; pointer still moves to B.
    applyStimulus(1, 0, 32'h1234, 0, 0, 0);
    runCycle();
    checkOutput("r0Rw", regwrite, 0);
    checkOutput("r0Wa", wa, 0);
    checkOutput("r0Wd", wd, 32'h1234);
    applyStimulus(1, 9, 32'h99, 1, 10, 32'hAA);
    #1 checkOutput("r0PtrReadyB", req_b_ready, 1);
    checkOutput("r0PtrReadyA", req_a_ready, 0);
    runCycle();
    req_b_valid = 1'b0;
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r0ThenA", wa, 9);

    // Requests held through INIT are ignored, then served A first, B next.
    doReset();
    applyStimulus(1, 11, 32'hA5, 1, 12, 32'hB5);
    for (int k = 1; k < NREG; k++) begin
      #1 checkOutput("initNoGrant", {req_a_ready, req_b_ready}, 0);
      runCycle();
    end
    #1 checkOutput("firstRunA", req_a_ready, 1);
    runCycle();
    req_a_valid = 1'b0;
    checkOutput("firstRunWa", wa, 11);
    #1 checkOutput("secondRunB", req_b_ready, 1);
    runCycle();
    req_b_valid = 1'b0;
    checkOutput("secondRunWa", wa, 12);
    checkOutput("secondRunRw", regwrite, 1);

    // Asynchronous reset while a write is on the port.
    reset = 1'b1;
    #1;
    checkOutput("asyncRw", regwrite, 0);
    checkOutput("asyncDone", init_done, 0);
    checkOutput("asyncWa", wa, 0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    runCycle();
    checkOutput("restartWa", wa, 1);
    checkOutput("restartRw", regwrite, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
